// File: rtl/types_pkg.sv
// Shared ALU types: opcodes, control mask and flag bundle.
// Used by the multi-precision sequencer and its ALU.
package types;

  typedef enum logic [2:0] {
    op_and,
    op_or,
    op_xor,
    op_add,
    op_rl,
    op_rr
  } opcode_t;

  typedef struct packed {
    logic s;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic sub;
    logic s;
    logic c;
  } ctl_t;

  typedef enum logic [1:0] {
    seq_madd,
    seq_msub,
    seq_shl,
    seq_shr
  } seq_op_t;

endpackage

// File: rtl/alu_seq_if.sv
// Execute-stage request/response bundle for alu_seq.
// master = execute stage, slave = sequencer.
interface alu_seq_if #(
  parameter int WIDTH  = 4,
  parameter int NWORDS = 4,
  parameter int CNT_W  = $clog2(NWORDS*WIDTH+1)
);
  logic                    req_valid;
  logic                    req_ready;
  logic [1:0]              req_op;
  logic                    req_arith;
  logic [CNT_W-1:0]        req_cnt;
  logic [NWORDS*WIDTH-1:0] req_a;
  logic [NWORDS*WIDTH-1:0] req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [NWORDS*WIDTH-1:0] rsp_data;
  types::flags_t           rsp_flags;

  modport master (
    output req_valid, req_op, req_arith,
    output req_cnt, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_data, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_arith,
    input  req_cnt, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_data, rsp_flags
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-precision add/sub/shift sequencer over one ALU.
// Optional abort input enabled by ALU_SEQ_ABORT_EN.
module alu_seq
  import types::*;
#(
  parameter int WIDTH  = 4,
  parameter int NWORDS = 4,
  parameter int CNT_W  = $clog2(NWORDS*WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ALU_SEQ_ABORT_EN
  input  logic             abort,
`endif
  alu_seq_if.slave         bus,
  output opcode_t          alu_opcode,
  output ctl_t             alu_bmask,
  output logic [WIDTH-1:0] alu_arg1,
  output logic [WIDTH-1:0] alu_arg2,
  output flags_t           alu_f,
  input  logic [WIDTH-1:0] alu_dout,
  input  flags_t           alu_fout
);

  localparam int TOT   = NWORDS * WIDTH;
  localparam int IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [NWORDS-1:0][WIDTH-1:0] wrk;
  logic [NWORDS-1:0][WIDTH-1:0] opb;
  seq_op_t          op_q;
  logic             arith_q;
  logic [CNT_W-1:0] pass_q;
  logic [IDX_W-1:0] idx_q;
  logic             cy_q;
  logic             v_q;

  logic [CNT_W-1:0] k_in;
  logic             shift_req;
  logic             is_shift;
  logic             down;
  logic             last_word;
  logic             step_done;
  logic             run_go;
  logic             unused_fout;

`ifdef ALU_SEQ_ABORT_EN
  assign run_go = !abort;
`else
  assign run_go = 1'b1;
`endif

  assign unused_fout = alu_fout.s ^ alu_fout.z;

  assign k_in = (bus.req_cnt > CNT_W'(TOT)) ?
                CNT_W'(TOT) : bus.req_cnt;
  assign shift_req = bus.req_op[1];
  assign is_shift  = op_q[1];
  assign down      = (op_q == seq_shr);
  assign last_word = down ? (idx_q == '0)
                          : (idx_q == LAST);
  assign step_done = last_word &&
                     (!is_shift || pass_q == 1);

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = wrk;

  // Whole-operand flags, only meaningful in DONE.
  always_comb begin
    bus.rsp_flags = '0;
    if (state_q == DONE) begin
      bus.rsp_flags.s = wrk[NWORDS-1][WIDTH-1];
      bus.rsp_flags.z = (wrk == '0);
      bus.rsp_flags.c = cy_q;
      bus.rsp_flags.v = v_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; zero-count shifts skip RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (bus.req_valid)
          state_d = (shift_req && k_in == '0) ?
                    DONE : RUN;
      RUN:
        if (!run_go)        state_d = IDLE;
        else if (step_done) state_d = DONE;
      DONE:
        if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU drive for the current word; idle op otherwise.
  always_comb begin
    alu_opcode = op_and;
    alu_bmask  = '0;
    alu_arg1   = '0;
    alu_arg2   = '0;
    alu_f      = '0;
    if (state_q == RUN) begin
      alu_arg1 = wrk[idx_q];
      unique case (op_q)
        seq_madd: begin
          alu_opcode  = op_add;
          alu_arg2    = opb[idx_q];
          alu_bmask.c = (idx_q != '0);
          alu_f.c     = cy_q;
        end
        seq_msub: begin
          alu_opcode    = op_add;
          alu_arg2      = opb[idx_q];
          alu_bmask.sub = 1'b1;
          alu_bmask.c   = 1'b1;
          alu_f.c       = (idx_q != '0) & cy_q;
        end
        seq_shl: begin
          alu_opcode  = op_rl;
          alu_bmask.c = 1'b1;
          alu_f.c     = (idx_q != '0) & cy_q;
        end
        seq_shr: begin
          alu_opcode  = op_rr;
          alu_bmask.c = (idx_q != LAST);
          alu_bmask.s = arith_q;
          alu_f.c     = cy_q;
        end
        default: alu_opcode = op_and;
      endcase
    end
  end

  // Operand capture and per-word write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrk     <= '0;
      opb     <= '0;
      op_q    <= seq_madd;
      arith_q <= 1'b0;
      pass_q  <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.req_valid) begin
          wrk     <= bus.req_a;
          opb     <= bus.req_b;
          op_q    <= seq_op_t'(bus.req_op);
          arith_q <= bus.req_arith;
          pass_q  <= k_in;
          idx_q   <= (bus.req_op == 2'b11) ?
                     LAST : '0;
          cy_q    <= 1'b0;
          v_q     <= 1'b0;
        end
        RUN: if (run_go) begin
          wrk[idx_q] <= alu_dout;
          cy_q <= (op_q == seq_msub) ?
                  ~alu_fout.c : alu_fout.c;
          if (last_word) begin
            if (!is_shift) v_q <= alu_fout.v;
            idx_q  <= down ? LAST : '0;
            pass_q <= pass_q - 1'b1;
          end else begin
            idx_q <= down ? idx_q - 1'b1
                          : idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq with a behavioural
// ALU and a whole-operand reference model.
module tb_alu_seq;
  import types::*;

  localparam int W   = 4;
  localparam int N   = 4;
  localparam int TOT = W * N;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W), .NWORDS(N)) bus ();

  opcode_t        alu_opcode;
  ctl_t           alu_bmask;
  logic [W-1:0]   alu_arg1, alu_arg2, alu_dout;
  flags_t         alu_f, alu_fout;
`ifdef ALU_SEQ_ABORT_EN
  logic abort;
`endif

  alu_seq #(.WIDTH(W), .NWORDS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef ALU_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .bus        (bus),
    .alu_opcode (alu_opcode),
    .alu_bmask  (alu_bmask),
    .alu_arg1   (alu_arg1),
    .alu_arg2   (alu_arg2),
    .alu_f      (alu_f),
    .alu_dout   (alu_dout),
    .alu_fout   (alu_fout)
  );

  logic [W-1:0] bb;
  logic         cin;
  logic [W:0]   sum;

  // Behavioural ALU: add with optional invert, rotates through carry.
  always_comb begin
    bb = '0;
    cin = 1'b0;
    sum = '0;
    alu_dout = '0;
    alu_fout = '0;
    case (alu_opcode)
      op_add: begin
        bb  = alu_bmask.sub ? ~alu_arg2 : alu_arg2;
        cin = alu_bmask.c &
              (alu_bmask.sub ? ~alu_f.c : alu_f.c);
        sum = {1'b0, alu_arg1} + {1'b0, bb} +
              {{W{1'b0}}, cin};
        alu_dout   = sum[W-1:0];
        alu_fout.c = sum[W];
        alu_fout.v = (alu_arg1[W-1] == bb[W-1]) &&
                     (sum[W-1] != alu_arg1[W-1]);
      end
      op_rl: begin
        alu_dout   = {alu_arg1[W-2:0],
                      alu_bmask.c & alu_f.c};
        alu_fout.c = alu_arg1[W-1];
      end
      op_rr: begin
        alu_dout   = {alu_bmask.c ? alu_f.c :
                      (alu_bmask.s & alu_arg1[W-1]),
                      alu_arg1[W-1:1]};
        alu_fout.c = alu_arg1[0];
      end
      default: alu_dout = alu_arg1 & alu_arg2;
    endcase
    alu_fout.s = alu_dout[W-1];
    alu_fout.z = (alu_dout == '0);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Whole-operand reference: plain arithmetic on 16-bit values.
  function automatic void ref_model(
    input int op, input bit arith, input int cnt,
    input logic [TOT-1:0] a, input logic [TOT-1:0] b,
    output logic [TOT-1:0] r, output logic [3:0] fl,
    output int lat);
    int k;
    logic [TOT:0] s;
    logic c, v;
    k = (cnt > TOT) ? TOT : cnt;
    c = 1'b0;
    v = 1'b0;
    r = a;
    lat = 1 + N;
    case (op)
      0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[TOT-1:0];
        c = s[TOT];
        v = (a[TOT-1] == b[TOT-1]) &&
            (r[TOT-1] != a[TOT-1]);
      end
      1: begin
        r = a - b;
        c = (a < b);
        v = (a[TOT-1] != b[TOT-1]) &&
            (r[TOT-1] != a[TOT-1]);
      end
      2: begin
        r = a << k;
        if (k > 0) c = a[TOT-k];
        lat = 1 + k * N;
      end
      default: begin
        if (arith) r = TOT'($signed(a) >>> k);
        else       r = a >> k;
        if (k > 0) c = a[k-1];
        lat = 1 + k * N;
      end
    endcase
    fl = {r[TOT-1], (r == '0), c, v};
  endfunction

  task automatic run_txn(
    input int op, input bit arith, input int cnt,
    input logic [TOT-1:0] a, input logic [TOT-1:0] b,
    input int hold, input bit dual,
    input logic [TOT-1:0] plan, input bit use_plan);
    logic [TOT-1:0] er, held;
    logic [3:0] ef;
    int el, n;
    ref_model(op, arith, cnt, a, b, er, ef, el);
    @(negedge clk);
    check("ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op[1:0];
    bus.req_arith = arith;
    bus.req_cnt   = cnt[4:0];
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = 16'($urandom);
    bus.req_b     = 16'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.rsp_valid)
        check("ready_busy", 32'(bus.req_ready), 0);
    end while (!bus.rsp_valid && n < 2000);
    check("latency", n, el);
    check("data", 32'(bus.rsp_data), 32'(er));
    check("flags", 32'(bus.rsp_flags), 32'(ef));
    if (use_plan)
      check("plan", 32'(bus.rsp_data), 32'(plan));
    held = bus.rsp_data;
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 1);
      check("hold_data", 32'(bus.rsp_data),
            32'(held));
      check("hold_ready", 32'(bus.req_ready), 0);
    end
    if (dual) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 2'($urandom);
      bus.req_cnt   = 5'd4;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("idle_after", 32'(bus.req_ready), 1);
    check("rsp_drop", 32'(bus.rsp_valid), 0);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_arith = 1'b0;
    bus.req_cnt   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 1);
    check("rst_valid", 32'(bus.rsp_valid), 0);
    check("rst_data", 32'(bus.rsp_data), 0);
    check("rst_flags", 32'(bus.rsp_flags), 0);
    check("rst_aluop", 32'(alu_opcode), 0);
    check("rst_arg1", 32'(alu_arg1), 0);

    run_txn(0, 0, 0, 16'h00FF, 16'h0001,
            0, 0, 16'h0100, 1);
    run_txn(1, 0, 0, 16'h0000, 16'h0001,
            0, 0, 16'hFFFF, 1);
    run_txn(1, 0, 0, 16'h1234, 16'h1234,
            0, 1, 16'h0000, 1);
    run_txn(0, 0, 0, 16'h7FFF, 16'h0001,
            0, 0, 16'h8000, 1);
    run_txn(2, 0, 1, 16'h8001, 16'h0000,
            0, 0, 16'h0002, 1);
    run_txn(3, 1, 3, 16'h8000, 16'h0000,
            0, 0, 16'hF000, 1);
    run_txn(3, 0, 3, 16'h8000, 16'h0000,
            10, 0, 16'h1000, 1);
    run_txn(2, 0, 0, 16'hBEEF, 16'h0000,
            0, 0, 16'hBEEF, 1);
    run_txn(3, 1, 20, 16'h8421, 16'h0000,
            1, 0, 16'hFFFF, 1);

    for (int i = 0; i < 40; i++)
      run_txn($urandom_range(0, 3),
              1'($urandom_range(0, 1)),
              $urandom_range(0, 20),
              16'($urandom), 16'($urandom),
              $urandom_range(0, 3),
              1'($urandom_range(0, 1)),
              16'h0, 0);

    // reset in the middle of RUN
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 16'h1357;
    bus.req_b     = 16'h2468;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(bus.req_ready), 1);
    check("mid_rst_valid", 32'(bus.rsp_valid), 0);
    check("mid_rst_data", 32'(bus.rsp_data), 0);
    repeat (6) @(negedge clk);
    check("mid_rst_quiet", 32'(bus.rsp_valid), 0);

`ifdef ALU_SEQ_ABORT_EN
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.req_cnt   = 5'd8;
    bus.req_a     = 16'hA5A5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(bus.req_ready), 1);
    check("abort_valid", 32'(bus.rsp_valid), 0);
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid)
        check("abort_quiet", 32'(bus.rsp_valid), 0);
    end
    run_txn(0, 0, 0, 16'h00FF, 16'h0001,
            0, 0, 16'h0100, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
